// File: rtl/mul_issue_sequencer_pkg.sv
// Shared types and constants for the multiply issue sequencer: FSM state encoding,
// RV32M decode constants and the latched issue record.
package mul_issue_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StWait   = 2'd2,
        StHold   = 2'd3
    } state_e;

    localparam logic [6:0] OpcodeOpR    = 7'b0110011;
    localparam logic [6:0] Funct7MulDiv = 7'b0000001;

    localparam logic [2:0] Funct3Mul    = 3'b000;
    localparam logic [2:0] Funct3Mulh   = 3'b001;
    localparam logic [2:0] Funct3Mulhsu = 3'b010;
    localparam logic [2:0] Funct3Mulhu  = 3'b011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [7:0]  accuracy;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } issue_fields_t;

    // Multiply group only; the divide half of M (funct3[2]=1) is rejected.
    function automatic logic is_mul(input logic [6:0] opcode, input logic [2:0] funct3,
                                    input logic [6:0] funct7);
        return (opcode == OpcodeOpR) && (funct7 == Funct7MulDiv) &&
               (funct3 inside {Funct3Mul, Funct3Mulh, Funct3Mulhsu, Funct3Mulhu});
    endfunction

endpackage

// File: rtl/mul_issue_sequencer_if.sv
// Issue, multiplier and result buses of the multiply issue sequencer.
// slave is the sequencer's view; master is the surrounding pipeline/multiplier.
interface mul_issue_sequencer_if;

    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic [6:0]  issue_funct7;
    logic        issue_accuracy_override;
    logic [7:0]  issue_accuracy;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [4:0]  issue_rd;
    logic        flush;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [7:0]  accuracy_level;
    logic [31:0] bus_rs1;
    logic [31:0] bus_rs2;
    logic        mul_unit_busy;
    logic [31:0] mul_output;

    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_value;
    logic [4:0]  result_rd;
    logic        stall;

    modport slave (
        input  issue_valid, issue_opcode, issue_funct3, issue_funct7,
               issue_accuracy_override, issue_accuracy, issue_rs1, issue_rs2, issue_rd,
               flush, mul_unit_busy, mul_output, result_ready,
        output issue_ready, opcode, funct3, funct7, accuracy_level, bus_rs1, bus_rs2,
               result_valid, result_value, result_rd, stall
    );

    modport master (
        output issue_valid, issue_opcode, issue_funct3, issue_funct7,
               issue_accuracy_override, issue_accuracy, issue_rs1, issue_rs2, issue_rd,
               flush, mul_unit_busy, mul_output, result_ready,
        input  issue_ready, opcode, funct3, funct7, accuracy_level, bus_rs1, bus_rs2,
               result_valid, result_value, result_rd, stall
    );

endinterface

// File: rtl/mul_issue_sequencer_latch.sv
// Operand/control register bank for one in-flight multiply; clear has priority over load.
module mul_issue_latch
    import mul_issue_sequencer_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          clear_i,
    input  issue_fields_t fields_i,
    output issue_fields_t fields_o
);

    issue_fields_t fields_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fields_q <= '0;
        end else if (clear_i) begin
            fields_q <= '0;
        end else if (load_i) begin
            fields_q <= fields_i;
        end
    end

    assign fields_o = fields_q;

endmodule

// File: rtl/mul_issue_sequencer.sv
// Sequencer in front of the multiplier: latch issue, hold operands, wait out busy, return product.
// Define MUL_PERF_COUNT_EN to add the completion and busy-cycle performance counters.
module mul_issue_sequencer
    import mul_issue_sequencer_pkg::*;
#(
    parameter int unsigned SettleCycles    = 1,
    parameter logic [7:0]  AccuracyDefault = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef MUL_PERF_COUNT_EN
    output logic [31:0]          perf_mul_count_o,
    output logic [31:0]          perf_busy_cycles_o,
`endif
    mul_issue_sequencer_if.slave bus
);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   result_q, result_d;
    logic          load, clear, accept, drive;
    issue_fields_t fields_in, fields;

    assign fields_in = '{
        opcode:   bus.issue_opcode,
        funct3:   bus.issue_funct3,
        funct7:   bus.issue_funct7,
        accuracy: bus.issue_accuracy_override ? bus.issue_accuracy : AccuracyDefault,
        rs1:      bus.issue_rs1,
        rs2:      bus.issue_rs2,
        rd:       bus.issue_rd
    };

    assign accept = bus.issue_valid && (state_q == StIdle) && !bus.flush &&
                    is_mul(bus.issue_opcode, bus.issue_funct3, bus.issue_funct7);

    mul_issue_latch u_latch (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (load),
        .clear_i  (clear),
        .fields_i (fields_in),
        .fields_o (fields)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        clear    = 1'b0;
        if (bus.flush) begin
            state_d  = StIdle;
            cnt_d    = '0;
            result_d = '0;
            clear    = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        load    = 1'b1;
                        state_d = StSettle;
                        cnt_d   = 4'd1;
                    end
                end
                StSettle: begin
                    if (cnt_q >= 4'(SettleCycles)) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StWait: begin
                    if (!bus.mul_unit_busy) begin
                        result_d = bus.mul_output;
                        state_d  = StHold;
                    end
                end
                StHold: begin
                    if (bus.result_ready) begin
                        state_d  = StIdle;
                        result_d = '0;
                        clear    = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Multiplier sees the latched issue only while it is settling or being waited on.
    assign drive              = (state_q == StSettle) || (state_q == StWait);
    assign bus.opcode         = drive ? fields.opcode   : '0;
    assign bus.funct3         = drive ? fields.funct3   : '0;
    assign bus.funct7         = drive ? fields.funct7   : '0;
    assign bus.accuracy_level = drive ? fields.accuracy : '0;
    assign bus.bus_rs1        = drive ? fields.rs1      : '0;
    assign bus.bus_rs2        = drive ? fields.rs2      : '0;

    assign bus.issue_ready  = (state_q == StIdle);
    assign bus.result_valid = (state_q == StHold);
    assign bus.result_value = result_q;
    assign bus.result_rd    = (state_q == StHold) ? fields.rd : '0;
    assign bus.stall        = (state_q != StIdle) && !((state_q == StHold) && bus.result_ready);

`ifdef MUL_PERF_COUNT_EN
    logic [31:0] perf_mul_count_q, perf_busy_cycles_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_mul_count_q   <= '0;
            perf_busy_cycles_q <= '0;
        end else begin
            if ((state_q == StHold) && (state_d == StIdle) && !bus.flush) begin
                perf_mul_count_q <= perf_mul_count_q + 32'd1;
            end
            if ((state_q == StWait) && bus.mul_unit_busy && !bus.flush) begin
                perf_busy_cycles_q <= perf_busy_cycles_q + 32'd1;
            end
        end
    end

    assign perf_mul_count_o   = perf_mul_count_q;
    assign perf_busy_cycles_o = perf_busy_cycles_q;
`endif

endmodule

// File: tb/tb_mul_issue_sequencer.sv
// Randomized self-checking bench for mul_issue_sequencer against a transaction-level model.
module tb_mul_issue_sequencer;

    localparam int unsigned Settle     = 2;
    localparam logic [7:0]  AccDefault = 8'h5A;
    localparam logic [6:0]  OpR        = 7'b0110011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_issue_sequencer_if bus ();

    mul_issue_sequencer #(
        .SettleCycles    (Settle),
        .AccuracyDefault (AccDefault)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_is_mul(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
        return (op == 7'b0110011) && (f7 == 7'b0000001) && (f3 < 3'd4);
    endfunction

    // The bench plays the multiplier: RV32M product semantics per funct3.
    function automatic logic [31:0] ref_product(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] as, au, bs, bu, p;
        as = {{32{a[31]}}, a};
        au = {32'd0, a};
        bs = {{32{b[31]}}, b};
        bu = {32'd0, b};
        case (f3)
            3'd0:    begin p = as * bs; return p[31:0];  end
            3'd1:    begin p = as * bs; return p[63:32]; end
            3'd2:    begin p = as * bu; return p[63:32]; end
            default: begin p = au * bu; return p[63:32]; end
        endcase
    endfunction

    task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input bit ovr, input logic [7:0] acc);
        bus.issue_valid             = 1'b1;
        bus.issue_opcode            = op;
        bus.issue_funct3            = f3;
        bus.issue_funct7            = f7;
        bus.issue_rs1               = a;
        bus.issue_rs2               = b;
        bus.issue_rd                = rd;
        bus.issue_accuracy_override = ovr;
        bus.issue_accuracy          = acc;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.issue_ready), 32'd1);
        check_eq({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check_eq({tag, "_rvalid"}, 32'(bus.result_valid), 32'd0);
        check_eq({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
    endtask

    // One full multiply: issue in cycle 0, busy seen for busy_n WAIT cycles, ready held off.
    task automatic run_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input bit ovr, input logic [7:0] acc,
                           input int busy_n, input int ready_delay);
        logic [31:0] prod;
        logic [7:0]  exp_acc;
        int          k;
        bit          seen;
        prod    = ref_product(f3, a, b);
        exp_acc = ovr ? acc : AccDefault;
        @(posedge clk); #1;
        check_eq("ready_before_issue", 32'(bus.issue_ready), 32'd1);
        present(OpR, f3, 7'b0000001, a, b, rd, ovr, acc);
        bus.mul_output    = prod;
        bus.mul_unit_busy = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clk); #1;
            k++;
            bus.issue_valid   = 1'b0;
            // Busy covers the settle window plus busy_n cycles of WAIT.
            bus.mul_unit_busy = (k <= int'(Settle) + busy_n);
            if (bus.result_valid) begin
                seen = 1'b1;
            end else begin
                check_eq("bus_rs1", bus.bus_rs1, a);
                check_eq("bus_rs2", bus.bus_rs2, b);
                check_eq("stall_inflight", 32'(bus.stall), 32'd1);
                if (k == 1) begin
                    check_eq("opcode_out", 32'(bus.opcode), 32'(OpR));
                    check_eq("funct3_out", 32'(bus.funct3), 32'(f3));
                    check_eq("funct7_out", 32'(bus.funct7), 32'd1);
                    check_eq("accuracy_out", 32'(bus.accuracy_level), 32'(exp_acc));
                end
            end
        end
        check_eq("latency", 32'(k), 32'(int'(Settle) + 2 + busy_n));
        bus.mul_output = ~prod;
        check_eq("result_value", bus.result_value, prod);
        check_eq("result_rd", 32'(bus.result_rd), 32'(rd));
        check_eq("hold_opcode_zero", 32'(bus.opcode), 32'd0);
        check_eq("hold_stall", 32'(bus.stall), 32'd1);
        present(OpR, 3'd0, 7'b0000001, $urandom, $urandom, 5'($urandom), 1'b0, 8'h00);
        for (int j = 0; j < ready_delay; j++) begin
            @(posedge clk); #1;
            check_eq("hold_rvalid", 32'(bus.result_valid), 32'd1);
            check_eq("hold_value_stable", bus.result_value, prod);
            check_eq("hold_rd_stable", 32'(bus.result_rd), 32'(rd));
            check_eq("hold_issue_ready", 32'(bus.issue_ready), 32'd0);
            check_eq("hold_stall_wait", 32'(bus.stall), 32'd1);
        end
        bus.result_ready = 1'b1;
        #1;
        check_eq("stall_on_ready", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        bus.issue_valid  = 1'b0;
        check_quiet("after_handoff");
    endtask

    task automatic run_non_mul();
        logic [6:0] op, f7;
        logic [2:0] f3;
        do begin
            op = 7'($urandom);
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                op = OpR;
                f7 = 7'($urandom_range(1, 0));
            end
        end while (ref_is_mul(op, f3, f7));
        @(posedge clk); #1;
        present(op, f3, f7, $urandom, $urandom, 5'($urandom), 1'b0, 8'h00);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            bus.issue_valid = 1'b0;
            check_quiet("non_mul");
        end
    endtask

    initial begin
        bus.issue_valid             = 1'b0;
        bus.issue_opcode            = '0;
        bus.issue_funct3            = '0;
        bus.issue_funct7            = '0;
        bus.issue_accuracy_override = 1'b0;
        bus.issue_accuracy          = '0;
        bus.issue_rs1               = '0;
        bus.issue_rs2               = '0;
        bus.issue_rd                = '0;
        bus.flush                   = 1'b0;
        bus.mul_unit_busy           = 1'b0;
        bus.mul_output              = '0;
        bus.result_ready            = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_value", bus.result_value, 32'd0);
        check_eq("reset_bus_rs1", bus.bus_rs1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul(3'd0, 32'd10, 32'd20, 5'd5, 1'b0, 8'h00, 0, 0);
        run_mul(3'd0, 32'hFFFF_FFFE, 32'd5, 5'd9, 1'b1, 8'hC3, 4, 0);
        run_mul(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 1'b0, 8'h00, 1, 5);

        // ADD must not be latched.
        @(posedge clk); #1;
        present(OpR, 3'd0, 7'b0000000, 32'd1, 32'd2, 5'd3, 1'b0, 8'h00);
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        check_quiet("add_ignored");

        // Flush while waiting on a busy multiplier.
        @(posedge clk); #1;
        present(OpR, 3'd1, 7'b0000001, 32'd7, 32'd8, 5'd4, 1'b0, 8'h00);
        bus.mul_unit_busy = 1'b1;
        repeat (Settle + 1) begin
            @(posedge clk); #1;
            bus.issue_valid = 1'b0;
        end
        check_eq("flush_pre_opcode", 32'(bus.opcode), 32'(OpR));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush         = 1'b0;
        bus.mul_unit_busy = 1'b0;
        check_quiet("flush_wait");
        repeat (3) @(posedge clk);
        #1;
        check_eq("flush_no_result", 32'(bus.result_valid), 32'd0);

        // Flush coinciding with an accept wins.
        present(OpR, 3'd0, 7'b0000001, 32'd3, 32'd3, 5'd1, 1'b0, 8'h00);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        check_quiet("flush_accept");

        // Asynchronous reset in SETTLE, checked between clock edges.
        @(posedge clk); #1;
        present(OpR, 3'd2, 7'b0000001, 32'hAAAA_5555, 32'd77, 5'd12, 1'b1, 8'h11);
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        check_eq("settle_opcode", 32'(bus.opcode), 32'(OpR));
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        check_eq("async_reset_rs1", bus.bus_rs1, 32'd0);
        check_eq("async_reset_acc", 32'(bus.accuracy_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                run_non_mul();
            end else begin
                run_mul(3'($urandom_range(3, 0)), $urandom, $urandom, 5'($urandom),
                        1'($urandom), 8'($urandom), int'($urandom_range(5, 0)),
                        int'($urandom_range(3, 0)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_issue_sequencer.md
Name: mul_issue_sequencer

Overview:
Execute-side sequencer directly upstream of the multiplier unit. It accepts M-extension multiply issues from the execute stage and latches their operands and control fields. It drives them steadily onto the multiplier's input bus, waits out the multiplier's busy indication, and captures the 32-bit product. It returns the product with a valid/ready handshake and asserts a pipeline stall while a multiply is outstanding.

Parameters:
SETTLE_CYCLES, 1, minimum cycles operands are held before busy is sampled (range 1..15)
ACCURACY_DEFAULT, 8'h00, accuracy_level driven when issue_accuracy_override=0

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
issue_valid  input  1  execute stage presents an instruction
issue_ready  output  1  sequencer can accept (IDLE only)
issue_opcode  input  7  instruction opcode
issue_funct3  input  3  instruction funct3
issue_funct7  input  7  instruction funct7
issue_accuracy_override  input  1  use issue_accuracy instead of ACCURACY_DEFAULT
issue_accuracy  input  8  per-instruction accuracy level
issue_rs1  input  32  operand A
issue_rs2  input  32  operand B
issue_rd  input  5  destination register index
flush  input  1  synchronous kill of the in-flight operation
opcode  output  7  to multiplier
funct3  output  3  to multiplier
funct7  output  7  to multiplier
accuracy_level  output  8  to multiplier
bus_rs1  output  32  to multiplier
bus_rs2  output  32  to multiplier
mul_unit_busy  input  1  from multiplier
mul_output  input  32  from multiplier
result_valid  output  1  product available
result_ready  input  1  writeback accepts product
result_value  output  32  captured product
result_rd  output  5  destination of product
stall  output  1  hold upstream pipeline

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except issue_ready=1; settle counter 0.
- Accept: issue_valid & issue_ready & is_mul, where is_mul = opcode 7'b0110011, funct7 7'b0000001, funct3[2]=0. Non-multiply issues are not latched and produce no result. issue_ready stays 1 for them.
- FSM:
  - IDLE: on accept, latch all fields into a register bank and go to SETTLE.
  - SETTLE: the counter runs 1..SETTLE_CYCLES. After SETTLE_CYCLES cycles, go to WAIT.
  - WAIT: if mul_unit_busy=0, capture mul_output into result_value and go to HOLD. Otherwise remain in WAIT.
  - HOLD: result_valid=1. On result_ready, go to IDLE.
- Latched fields drive the multiplier outputs from the cycle after accept until leaving WAIT. In IDLE and HOLD those outputs are 0, with opcode=0 so the multiplier decodes no operation.
- Latency: best case accept -> result_valid = SETTLE_CYCLES+2 cycles.
- stall: asserted the cycle after accept and held through HOLD. Deasserted in the cycle result_ready is sampled high.
- result_value and result_rd: hold stable while result_valid=1 and result_ready=0.
- flush: any state returns to IDLE next cycle and result_valid drops. A flush in the same cycle as an accept wins: nothing is latched.
- Simultaneous result_ready and issue_valid in HOLD: the new issue is not accepted that cycle, because issue_ready=1 only in IDLE.
- Reset mid-operation: immediate return to the reset state. The in-flight product is discarded.

Optional Feature:
MUL_PERF_COUNT_EN
- Defined: adds outputs perf_mul_count[31:0] and perf_busy_cycles[31:0].
  - perf_mul_count increments on each HOLD->IDLE completion.
  - perf_busy_cycles increments on each WAIT cycle with mul_unit_busy=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, SETTLE=2'd1, WAIT=2'd2, HOLD=2'd3), the OP_R opcode constant, the MULDIV funct7 constant, and the funct3 encodings MUL/MULH/MULHSU/MULHU.
- Natural sub-module: mul_issue_latch, the operand/control register bank with load and clear.

Test Plan:
- Reset, then issue MUL with rs1=10, rs2=20, rd=5, mul_output model=200 with busy 0 -> result_valid after 3 cycles; result_value=200, result_rd=5; stall high for the duration.
- Multiplier busy held 4 cycles, product 32'hFFFF_FFF6 -> result_valid after 7 cycles; bus_rs1/bus_rs2 stable throughout.
- result_ready held low 5 cycles in HOLD -> result_value stable; issue_ready=0; stall=1; second issue_valid ignored.
- Issue ADD (funct7=0) -> no latch, no stall, no result_valid.
- flush asserted in WAIT -> IDLE next cycle; no result_valid; opcode output returns to 0.
- reset pulsed low in SETTLE -> all outputs at reset values immediately, without waiting for a clock edge.
